// File: rtl/flappy_pkg.sv
// Shared constants and state encodings for the Flappy VGA game blocks.
package flappy_pkg;

  localparam int SCR_W   = 640;
  localparam int SCR_H   = 480;
  localparam int X0      = 640;
  localparam int X1      = 960;
  localparam int GAP0    = 180;
  localparam int GAP_MIN = 60;

  // One-hot so the renderer and flight_physics can use the state bits directly.
  typedef enum logic [2:0] {
    QIdle = 3'b001,
    QRun  = 3'b010,
    QHit  = 3'b100
  } state_t;

endpackage

// File: rtl/pipe_lane.sv
// One scrolling pipe: position and gap registers, wrap/reload, bird overlap test
// and the strobe that fires when the pipe's right edge lines up with the bird.
module pipe_lane
  import flappy_pkg::*;
#(
  parameter int X_INIT = X0,
  parameter int PIPE_W = 40,
  parameter int GAP_H  = 120
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       tick,
  input  logic [7:0] lfsr,
  input  logic [9:0] bird_x_l,
  input  logic [9:0] bird_x_r,
  input  logic [9:0] bird_y_t,
  input  logic [9:0] bird_y_b,
  output logic [9:0] pipe_x,
  output logic [9:0] gap_t,
  output logic       overlap,
  output logic       pass
);

  logic [10:0] right_edge;
  logic [10:0] gap_b;

  // 11-bit sums so a pipe near X=1023 or a deep gap never wraps.
  assign right_edge = {1'b0, pipe_x} + 11'(PIPE_W);
  assign gap_b      = {1'b0, gap_t} + 11'(GAP_H);

  assign overlap = (bird_x_r > pipe_x) && ({1'b0, bird_x_l} < right_edge) &&
                   ((bird_y_t < gap_t) || ({1'b0, bird_y_b} > gap_b));
  assign pass    = (right_edge == {1'b0, bird_x_l});

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) begin
      pipe_x <= 10'(X_INIT);
      gap_t  <= 10'(GAP0);
    end else if (clear) begin
      pipe_x <= 10'(X_INIT);
      gap_t  <= 10'(GAP0);
    end else if (tick) begin
      if (pipe_x == 10'd0) begin
        pipe_x <= 10'(SCR_W);
        gap_t  <= 10'(GAP_MIN) + {2'b00, lfsr};
      end else begin
        pipe_x <= pipe_x - 10'd1;
      end
    end
  end

endmodule

// File: rtl/pipe_collision.sv
// Obstacle and referee engine: scrolls two pipes, detects bird hits against
// pipes and ground, raises Stop, and keeps the pipes-cleared score.
module pipe_collision
  import flappy_pkg::*;
#(
  parameter int PIPE_W     = 40,
  parameter int GAP_H      = 120,
  parameter int SCROLL_DIV = 500000,
  parameter int DIV_W      = 20
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       Start,
  input  logic       Ack,
  input  logic [9:0] Bird_X_L,
  input  logic [9:0] Bird_X_R,
  input  logic [9:0] Bird_Y_T,
  input  logic [9:0] Bird_Y_B,
  output logic       Stop,
  output logic [9:0] Pipe0_X,
  output logic [9:0] Pipe1_X,
  output logic [9:0] Pipe0_GapT,
  output logic [9:0] Pipe1_GapT,
  output logic [7:0] Score,
  output logic       q_Idle,
  output logic       q_Run,
  output logic       q_Hit
);

  state_t           state, state_next;
  logic [DIV_W-1:0] div_cnt;
  logic [7:0]       lfsr;
  logic             ov0, ov1, pass0, pass1;
  logic             ground, hit, div_end, tick, clear;

  assign ground  = ({1'b0, Bird_Y_B} >= 11'(SCR_H));
  assign hit     = (state == QRun) && (ov0 || ov1 || ground);
  assign div_end = (div_cnt == DIV_W'(SCROLL_DIV - 1));
  // A hit cycle suppresses scrolling, wrapping and scoring.
  assign tick    = (state == QRun) && !hit && div_end;

  always_comb begin
    state_next = QIdle;
    case (state)
      QIdle:   state_next = Start ? QRun : QIdle;
      QRun:    state_next = hit ? QHit : QRun;
      QHit:    state_next = Ack ? QIdle : QHit;
      default: state_next = QIdle;
    endcase
  end

  // Pipes and divider sit at reset values whenever we are (or are going) idle.
  assign clear = (state_next == QIdle);

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) state <= QIdle;
    else       state <= state_next;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)                       div_cnt <= '0;
    else if (clear)                  div_cnt <= '0;
    else if (state == QRun && !hit)  div_cnt <= div_end ? '0 : div_cnt + 1'b1;
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset) lfsr <= 8'hA5;
    else       lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
  end

  always_ff @(posedge Clk or posedge reset) begin
    if (reset)                                         Score <= 8'd0;
    else if (state == QIdle && Start)                  Score <= 8'd0;
    else if (tick && (pass0 || pass1) && Score != 8'hFF) Score <= Score + 8'd1;
  end

  pipe_lane #(.X_INIT(X0), .PIPE_W(PIPE_W), .GAP_H(GAP_H)) u_lane0 (
    .Clk(Clk), .reset(reset), .clear(clear), .tick(tick), .lfsr(lfsr),
    .bird_x_l(Bird_X_L), .bird_x_r(Bird_X_R), .bird_y_t(Bird_Y_T), .bird_y_b(Bird_Y_B),
    .pipe_x(Pipe0_X), .gap_t(Pipe0_GapT), .overlap(ov0), .pass(pass0)
  );

  pipe_lane #(.X_INIT(X1), .PIPE_W(PIPE_W), .GAP_H(GAP_H)) u_lane1 (
    .Clk(Clk), .reset(reset), .clear(clear), .tick(tick), .lfsr(lfsr),
    .bird_x_l(Bird_X_L), .bird_x_r(Bird_X_R), .bird_y_t(Bird_Y_T), .bird_y_b(Bird_Y_B),
    .pipe_x(Pipe1_X), .gap_t(Pipe1_GapT), .overlap(ov1), .pass(pass1)
  );

  assign q_Idle = state[0];
  assign q_Run  = state[1];
  assign q_Hit  = state[2];
  assign Stop   = q_Hit;

endmodule
